// File: rtl/mips_ifetch_unit.sv
// MIPS instruction-fetch front end: owns the PC, drives the combinational I-RAM port and hands
// fetched words to decode over valid/ready, with delay-slot redirects, halt-at-address and fault stop.
module mips_ifetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        fault_q, fault_d;
  logic        pend_valid_q, pend_valid_d;

  logic        redir_ok, redir_bad, at_halt, fetch;
  logic [31:0] next_pc;

  always_comb begin
    redir_ok  = active_q && redirect_valid && (redirect_target[1:0] == 2'b00);
    redir_bad = active_q && redirect_valid && (redirect_target[1:0] != 2'b00);
    at_halt   = (pc_q == HALT_ADDR);
    fetch     = active_q && !at_halt && (!valid_q || instr_ready);
    // A live redirect overrides an older pending one; a misaligned one never reaches the PC.
    next_pc   = redir_ok ? redirect_target : (pend_valid_q ? pend_target_q : pc_q + 32'd4);

    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    count_d       = count_q;
    pend_target_d = pend_target_q;
    valid_d       = valid_q;
    active_d      = active_q;
    fault_d       = fault_q;
    pend_valid_d  = pend_valid_q;

    if (fetch) begin
      instr_d      = instr_readdata;
      pc_out_d     = pc_q;
      valid_d      = 1'b1;
      count_d      = count_q + 32'd1;
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
    end else begin
      if (valid_q && instr_ready) valid_d = 1'b0;
      // Delay slot not yet fetched: park the target until the next advance.
      if (redir_ok) begin
        pend_target_d = redirect_target;
        pend_valid_d  = 1'b1;
      end
    end

    if (redir_bad) begin
      fault_d  = 1'b1;
      active_d = 1'b0;
    end
    if (active_q && at_halt) active_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      pc_out_q      <= '0;
      count_q       <= '0;
      pend_target_q <= '0;
      valid_q       <= 1'b0;
      active_q      <= 1'b1;
      fault_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      count_q       <= count_d;
      pend_target_q <= pend_target_d;
      valid_q       <= valid_d;
      active_q      <= active_d;
      fault_q       <= fault_d;
      pend_valid_q  <= pend_valid_d;
    end
  end

  assign instr_address = pc_q;
  assign instr_valid   = valid_q;
  assign instr_out     = instr_q;
  assign pc_out        = pc_out_q;
  assign active        = active_q;
  assign fetch_fault   = fault_q;
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_mips_ifetch_unit.sv
// Directed scenarios plus a randomized stall/redirect run checked against an address-stream model.
module tb_mips_ifetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        active;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'hBFC00000: mem = 32'h8C020000;
      32'hBFC00004: mem = 32'h8C030004;
      32'hBFC00008: mem = 32'h00000008;
      32'hBFC0000C: mem = 32'h24020000;
      default:      mem = a ^ 32'hA5A50F0F;
    endcase
  endfunction

  assign instr_readdata = mem(instr_address);

  mips_ifetch_unit dut (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .active(active), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_addr",  instr_address, RV);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pcout", pc_out, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd1);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #2 reset = 1'b1;
    #1 chk_reset_state();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Address-stream model for the random phase: cur = word held for decode, nxt = next word fetched.
  logic [31:0] m_cur, m_nxt, m_pt, m_cnt, tgt;
  logic        m_valid, m_pv, rdy, rv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: sequential fetch
    do_reset();
    cyc();
    chk("t1_instr0", instr_out, 32'h8C020000);
    chk("t1_pc0", pc_out, 32'hBFC00000);
    chk("t1_valid0", {31'b0, instr_valid}, 32'd1);
    cyc();
    chk("t1_instr1", instr_out, 32'h8C030004);
    chk("t1_pc1", pc_out, 32'hBFC00004);
    chk("t1_count", fetch_count, 32'd2);

    // 2: decode stall freezes everything
    do_reset();
    cyc();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_stall_pc", pc_out, 32'hBFC00000);
      chk("t2_stall_instr", instr_out, 32'h8C020000);
      chk("t2_stall_addr", instr_address, 32'hBFC00004);
      chk("t2_stall_count", fetch_count, 32'd1);
    end
    instr_ready = 1'b1;
    cyc();
    chk("t2_resume_pc", pc_out, 32'hBFC00004);
    chk("t2_resume_count", fetch_count, 32'd2);
    cyc();
    chk("t2_next_pc", pc_out, 32'hBFC00008);

    // 3: branch with delay slot
    do_reset();
    cyc(); cyc(); cyc();
    chk("t3_branch", pc_out, 32'hBFC00008);
    redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_dslot", pc_out, 32'hBFC0000C);
    cyc();
    chk("t3_tgt0", pc_out, 32'hBFC00100);
    chk("t3_tgt0_instr", instr_out, 32'hBFC00100 ^ 32'hA5A50F0F);
    cyc();
    chk("t3_tgt1", pc_out, 32'hBFC00104);

    // 4: redirect arriving during a stall waits
    do_reset();
    cyc(); cyc(); cyc();
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hBFC00200;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t4_stall_pc", pc_out, 32'hBFC00008);
    chk("t4_stall_addr", instr_address, 32'hBFC0000C);
    instr_ready = 1'b1;
    cyc();
    chk("t4_dslot", pc_out, 32'hBFC0000C);
    cyc();
    chk("t4_tgt0", pc_out, 32'hBFC00200);
    cyc();
    chk("t4_tgt1", pc_out, 32'hBFC00204);

    // 5: jr r0 halts after the delay slot drains
    do_reset();
    cyc(); cyc(); cyc();
    chk("t5_jr", instr_out, 32'h00000008);
    redirect_valid = 1'b1; redirect_target = 32'h00000000;
    cyc();
    redirect_valid = 1'b0;
    chk("t5_dslot", instr_out, 32'h24020000);
    chk("t5_addr0", instr_address, 32'h00000000);
    chk("t5_active_still", {31'b0, active}, 32'd1);
    cyc();
    chk("t5_active_off", {31'b0, active}, 32'd0);
    chk("t5_valid_off", {31'b0, instr_valid}, 32'd0);
    chk("t5_count", fetch_count, 32'd4);
    redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t5_ignored_addr", instr_address, 32'h00000000);
    chk("t5_frozen_count", fetch_count, 32'd4);
    chk("t5_still_invalid", {31'b0, instr_valid}, 32'd0);

    // 6: misaligned target faults; async reset recovers
    do_reset();
    cyc(); cyc();
    redirect_valid = 1'b1; redirect_target = 32'hBFC00102;
    cyc();
    redirect_valid = 1'b0;
    chk("t6_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t6_inactive", {31'b0, active}, 32'd0);
    chk("t6_dslot", pc_out, 32'hBFC00008);
    chk("t6_dslot_valid", {31'b0, instr_valid}, 32'd1);
    cyc();
    chk("t6_drained", {31'b0, instr_valid}, 32'd0);
    chk("t6_count", fetch_count, 32'd3);
    cyc();
    chk("t6_fault_sticky", {31'b0, fetch_fault}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_state();
    @(negedge clk);
    reset = 1'b0;
    cyc();
    chk("t6_restart", pc_out, RV);
    chk("t6_restart_instr", instr_out, 32'h8C020000);

    // Random stalls and redirects against the model
    do_reset();
    m_valid = 1'b0; m_nxt = RV; m_cur = '0; m_cnt = '0; m_pv = 1'b0; m_pt = '0;
    for (int c = 0; c < 300; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 5) == 0);
      tgt = RV + ($urandom_range(0, 1023) << 2);
      instr_ready = rdy; redirect_valid = rv; redirect_target = tgt;
      if (!m_valid || rdy) begin
        m_cur = m_nxt; m_cnt = m_cnt + 1; m_valid = 1'b1;
        m_nxt = rv ? tgt : (m_pv ? m_pt : m_nxt + 32'd4);
        m_pv = 1'b0;
      end else if (rv) begin
        m_pt = tgt; m_pv = 1'b1;
      end
      cyc();
      chk("rnd_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("rnd_pc", pc_out, m_cur);
      chk("rnd_instr", instr_out, mem(m_cur));
      chk("rnd_addr", instr_address, m_nxt);
      chk("rnd_count", fetch_count, m_cnt);
    end
    redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
